// File: rtl/kid_group_if.sv
// -----------------------------------------------------------------------------
// kid_group_if: meal server <-> kid group bus.
//   meal_valid  server -> group  one meal offered this cycle
//   book[N]     server -> group  book offered to each kid
//   request[N]  group -> server  registered, kid is hungry (one-cycle lag)
//   meal_grant  group -> server  combinational one-hot meal taker
//   meal_miss   group -> server  registered pulse, meal offered to nobody
//   starve[N]   group -> server  registered, kid hungry too long
// master = meal server side, slave = kid_group side.
// -----------------------------------------------------------------------------
interface kid_group_if #(parameter int N = 4);
  logic         meal_valid;
  logic [N-1:0] book;
  logic [N-1:0] request;
  logic [N-1:0] meal_grant;
  logic         meal_miss;
  logic [N-1:0] starve;

  modport master (output meal_valid, book,
                  input  request, meal_grant, meal_miss, starve);
  modport slave  (input  meal_valid, book,
                  output request, meal_grant, meal_miss, starve);
endinterface

// File: rtl/kid_group.sv
// -----------------------------------------------------------------------------
// kid_group: N independent HUNGRY/FULL/STUDY kid FSMs sharing one meal server
// through a round-robin arbiter.
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    kid_group_if.slave (meal_valid, book in; request, meal_grant,
//          meal_miss, starve out)
// Parameters: N kids (2..16), STUDY_CYC cycles spent studying (>=1),
// STARVE_LIM hungry cycles before starve is raised (>=1).
// Optional feature: define KID_STARVE_EN to build per-kid hunger counters;
// without it starve is tied low.
// -----------------------------------------------------------------------------

// One kid: state machine, study timer, registered request and starve flag.
module kid_lane #(
  parameter int STUDY_CYC  = 3,
  parameter int STARVE_LIM = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic grant,
  input  logic book,
  output logic hungry,
  output logic request_q,
  output logic starve_q
);
  localparam int CW = $clog2(STUDY_CYC + 1);

  if (STUDY_CYC < 1 || STARVE_LIM < 1) begin : g_bad_param
    $error("kid_lane: STUDY_CYC and STARVE_LIM must be >= 1");
  end

  typedef enum logic [1:0] {
    HUNGRY = 2'b00,
    FULL   = 2'b01,
    STUDY  = 2'b10
  } kid_state_e;

  kid_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          request_d;

  assign hungry = (state_q == HUNGRY);

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;          // counter is only meaningful inside STUDY
    request_d = hungry;
    case (state_q)
      HUNGRY: if (grant) state_d = FULL;
      FULL:   if (book)  state_d = STUDY;
      STUDY: begin
        if (cnt_q == CW'(STUDY_CYC - 1)) state_d = HUNGRY;
        else                             cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = HUNGRY; // 2'b11 recovers on the next edge
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HUNGRY;
      cnt_q     <= '0;
      request_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      request_q <= request_d;
    end
  end

`ifdef KID_STARVE_EN
  localparam int HW = $clog2(STARVE_LIM + 1);
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          starve_d;

  // Counts only while the kid stays hungry across the edge, so leaving
  // HUNGRY clears it at the grant edge and starve drops one edge later.
  always_comb begin
    hcnt_d   = '0;
    starve_d = (hcnt_q == HW'(STARVE_LIM));
    if (hungry && state_d == HUNGRY)
      hcnt_d = (hcnt_q == HW'(STARVE_LIM)) ? hcnt_q : hcnt_q + HW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      starve_q <= starve_d;
    end
  end
`else
  assign starve_q = 1'b0;
`endif
endmodule

module kid_group #(
  parameter int N          = 4,
  parameter int STUDY_CYC  = 3,
  parameter int STARVE_LIM = 8
) (
  input  logic       clk,
  input  logic       reset,
  kid_group_if.slave bus
);
  localparam int PW = $clog2(N);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("kid_group: N must be in 2..16");
  end

  logic [N-1:0]  hungry, grant, request_q, starve_q;
  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic          found;
  logic          meal_miss_q, meal_miss_d;

  for (genvar i = 0; i < N; i++) begin : g_kid
    kid_lane #(.STUDY_CYC(STUDY_CYC), .STARVE_LIM(STARVE_LIM)) u_kid (
      .clk       (clk),
      .reset     (reset),
      .grant     (grant[i]),
      .book      (bus.book[i]),
      .hungry    (hungry[i]),
      .request_q (request_q[i]),
      .starve_q  (starve_q[i])
    );
  end

  // Round-robin search from ptr; first hungry kid wins. Held off in reset.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      idx = PW'((int'(ptr_q) + off) % N);
      if (!found && hungry[idx] && bus.meal_valid && !reset) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = PW'((int'(idx) + 1) % N);
      end
    end
    meal_miss_d = bus.meal_valid & ~(|hungry);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      meal_miss_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      meal_miss_q <= meal_miss_d;
    end
  end

  assign bus.meal_grant = grant;
  assign bus.request    = request_q;
  assign bus.meal_miss  = meal_miss_q;
  assign bus.starve     = starve_q;
endmodule

// File: doc/kid_group.md
# kid_group

Parametrised group of N independent kid state machines (HUNGRY/FULL/STUDY) sharing one meal server. A round-robin arbiter hands each offered meal to exactly one hungry kid. Each kid stays in STUDY for a programmable number of cycles before it becomes hungry again. The block sits in the week-level FSM exercises as the multi-channel generalisation of the single-kid controller, and feeds a meal-dispensing FSM upstream.

## Interface
- N, 4: number of kids (channels), 2..16
- STUDY_CYC, 3: cycles spent in STUDY, ≥1 (1 reproduces the single-cycle study of the one-kid block)
- STARVE_LIM, 8: hungry-cycle threshold for the starve flag, ≥1 (used only with KID_STARVE_EN)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- meal_valid  input  1  one meal offered this cycle
- book  input  N  book[i] offered to kid i
- request  output  N  registered; kid i asks for a meal
- meal_grant  output  N  combinational one-hot; kid i takes this cycle's meal
- meal_miss  output  1  registered pulse; a meal was offered with no hungry kid
- starve  output  N  registered; kid i hungry for ≥STARVE_LIM cycles

## Operation
- Per-kid state: HUNGRY=2'b00, FULL=2'b01, STUDY=2'b10. The encoding 2'b11 is illegal; it returns to HUNGRY on the next edge.
- HUNGRY → FULL when meal_grant[i]=1; otherwise stays HUNGRY.
- FULL → STUDY when book[i]=1; otherwise stays FULL. A book offered in HUNGRY or STUDY is ignored.
- STUDY:
  - A study counter (width $clog2(STUDY_CYC+1)) is loaded with 0 on entry and increments each cycle.
  - When counter = STUDY_CYC-1 the kid goes → HUNGRY, so STUDY lasts exactly STUDY_CYC cycles.
- Arbiter:
  - A round-robin pointer ptr (width $clog2(N)) selects the search start.
  - meal_grant is the first kid at index ptr, ptr+1, … (mod N) whose state is HUNGRY, gated by meal_valid.
  - At most one grant bit is set per cycle. meal_grant = 0 when meal_valid=0.
  - After a grant to kid k, ptr ← (k+1) mod N. With no grant, ptr holds.
- request[i] ← (state[i]==HUNGRY), registered. It lags the state by one cycle, as in the single-kid block. Grants use the state, not request.
- meal_miss ← meal_valid & (no kid HUNGRY), registered, one-cycle pulse per wasted meal.
- Kids are fully independent except for the shared arbiter. Any mix of simultaneous transitions across kids is legal.

## Timing
- Reset (asynchronous, any time, including mid-STUDY or mid-grant):
  - All kids → HUNGRY, all counters → 0, ptr → 0.
  - request=0, meal_miss=0, starve=0.
  - meal_grant follows the reset state combinationally. It is 0 while reset=1; the arbiter is held off during reset.
- First rising edge after reset release: request = all ones.
- Grant latency:
  - meal_grant asserts in the same cycle as meal_valid.
  - The kid's state changes at that edge.
  - request[i] drops one edge later.
- Full cycle for one kid with book held high: HUNGRY → (grant) FULL (1 cycle) → STUDY (STUDY_CYC cycles) → HUNGRY.
- All kids HUNGRY with meal_valid held high: grants rotate 0,1,…,N-1,0,… one per cycle.
- Pointer wrap: a grant to kid N-1 sets ptr to 0.

## Configuration
- KID_STARVE_EN defined:
  - Each kid has a saturating hunger counter (width $clog2(STARVE_LIM+1)).
  - The counter increments every cycle in HUNGRY and clears on leaving HUNGRY or on reset.
  - starve[i] ← (counter == STARVE_LIM), registered.
  - starve drops one edge after the kid leaves HUNGRY.
- KID_STARVE_EN undefined:
  - No hunger counters are built.
  - starve is tied to 0; the port remains present.

## Test plan
All scenarios use N=4, STUDY_CYC=3, STARVE_LIM=8.
- Reset release, no stimulus:
  - request=4'b0000 before the first edge, 4'b1111 after it.
  - meal_grant=0, meal_miss=0.
- meal_valid high for 4 cycles, book=0:
  - meal_grant sequence 0001, 0010, 0100, 1000; request goes to 0000.
  - A 5th meal gives meal_miss=1 on the next edge.
- Kid 2 fed, then book[2]=1 for one cycle:
  - Kid 2 spends exactly 3 cycles in STUDY, then is HUNGRY.
  - request[2]=1 one edge after the return.
- Fairness: kids 0 and 3 hungry, ptr=1, meal_valid=1 → grant 1000, then ptr=0 → next grant 0001.
- Reset asserted mid-STUDY with kid 1 at study count 1:
  - All kids HUNGRY immediately, request=0.
  - After release, kid 1 behaves as freshly reset.
- KID_STARVE_EN defined, no meals:
  - starve=1111 asserted on the edge after the hunger counter reaches 8.
  - Feeding kid 0 clears starve[0] one edge after the grant.
  - Without the macro, starve stays 0000.
